// File: rtl/adc_pkg.sv
// Shared ADC scan definitions: FSM encoding, default widths, sample field layout.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package adc_pkg;

  // Default configuration of the scan sequencer and its neighbours
  localparam int ADC_N_CHAN = 11;
  localparam int ADC_CHAN_W = 4;
  localparam int ADC_DATA_W = 12;
  localparam int ADC_DLY_W  = 16;

  // Sequencer state encoding (3 bits leaves room for the averaging sub-state)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SCAN  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_STORE = 3'd4;
  localparam logic [2:0] ST_ACCUM = 3'd5;

  // Sample word layout {channel, result}; the sample FIFO and host readout
  // slice the stored word with these offsets.
  localparam int OUT_DATA_LSB = 0;
  localparam int OUT_CHAN_LSB = ADC_DATA_W;

endpackage

// File: rtl/adc_chan_walker.sv
// Channel walker: holds the latched scan mask and the current channel index.
// Latency: load/advance take effect on the next clock edge; outputs are combinational from state.
// Backpressure: none; the sequencer FSM decides when to load or advance.
module adc_chan_walker
  import adc_pkg::*;
#(
  parameter int N_CHAN = ADC_N_CHAN,
  parameter int CHAN_W = ADC_CHAN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [N_CHAN-1:0] mask_in,
  input  logic              advance,
  output logic [CHAN_W-1:0] chan,
  output logic              chan_en,
  output logic              last
);

  logic [N_CHAN-1:0] mask_q;
  logic [CHAN_W-1:0] cnt_q;

  // Latch the mask at a scan boundary and step through the channels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      mask_q <= mask_in;
      cnt_q  <= '0;
    end else if (advance) begin
      cnt_q  <= cnt_q + CHAN_W'(1);
    end
  end

  // Select the enable bit of the current channel (loop keeps index widths exact)
  always_comb begin
    chan_en = 1'b0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (cnt_q == CHAN_W'(i)) chan_en = mask_q[i];
    end
  end

  assign chan = cnt_q;
  assign last = (cnt_q == CHAN_W'(N_CHAN - 1));

endmodule

// File: rtl/adc_scan_seq.sv
// Multi-channel ADC scan sequencer: walks the channel mask, requests conversions, emits {chan,result} samples.
// Latency: start -> conv_req 2 cycles (channel 0 enabled); conv_done -> out_valid 1 cycle; disabled channel 1 cycle.
// Backpressure: none; sample consumer must accept every out_valid. Optional averaging via ADC_SCAN_AVG_EN.
module adc_scan_seq
  import adc_pkg::*;
#(
  parameter int N_CHAN    = ADC_N_CHAN,
  parameter int CHAN_W    = ADC_CHAN_W,
  parameter int DATA_W    = ADC_DATA_W,
  parameter int DLY_W     = ADC_DLY_W,
`ifdef ADC_SCAN_AVG_EN
  parameter int AVG_LOG2  = 2,
`endif
  parameter int INTER_DLY = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     mode_cont,
  input  logic [N_CHAN-1:0]        chan_mask,
  input  logic [DLY_W-1:0]         first_dly,
  output logic                     conv_req,
  output logic [CHAN_W-1:0]        conv_chan,
  output logic [DLY_W-1:0]         conv_dly,
  input  logic                     conv_done,
  input  logic [DATA_W-1:0]        conv_data,
  output logic                     out_valid,
  output logic [CHAN_W+DATA_W-1:0] out_data,
  output logic                     busy,
  output logic                     scan_done,
  output logic                     overrun
);

  logic [2:0]               state_q, state_d;
  logic                     first_q;
  logic                     cont_q;
  logic                     stop_pend_q;
  logic                     overrun_q;
  logic                     scan_done_q;
  logic                     out_valid_q;
  logic [CHAN_W+DATA_W-1:0] out_data_q;
  logic [DLY_W-1:0]         conv_dly_q;

  logic                     stop_eff;
  logic                     accept;
  logic                     w_load;
  logic                     w_adv;
  logic                     eos;
  logic                     to_issue;
  logic [CHAN_W-1:0]        w_chan;
  logic                     w_en;
  logic                     w_last;

`ifdef ADC_SCAN_AVG_EN
  logic [AVG_LOG2-1:0]        rep_q;
  logic [DATA_W+AVG_LOG2-1:0] acc_q;
  logic [DATA_W+AVG_LOG2-1:0] acc_sum;
  logic                       rep_last;

  assign acc_sum  = acc_q + {{AVG_LOG2{1'b0}}, conv_data};
  assign rep_last = &rep_q;
`endif

  // A stop seen this cycle acts immediately, without waiting for the sticky flag
  assign stop_eff = stop_pend_q | stop;

  adc_chan_walker #(
    .N_CHAN (N_CHAN),
    .CHAN_W (CHAN_W)
  ) u_walker (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_load),
    .mask_in (chan_mask),
    .advance (w_adv),
    .chan    (w_chan),
    .chan_en (w_en),
    .last    (w_last)
  );

  // Next-state logic; end-of-scan is resolved after the per-state decisions
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    w_load   = 1'b0;
    w_adv    = 1'b0;
    eos      = 1'b0;
    to_issue = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // stop in the same cycle as start wins: remain idle
        if (start && !stop) begin
          accept  = 1'b1;
          w_load  = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (stop_eff) begin
          state_d = ST_IDLE;
        end else if (w_en) begin
          state_d  = ST_ISSUE;
          to_issue = 1'b1;
        end else if (w_last) begin
          eos = 1'b1;
        end else begin
          w_adv = 1'b1;
        end
      end
      ST_ISSUE: begin
        // conv_req is suppressed when stop is pending, so nothing is in flight
        state_d = stop_eff ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        if (conv_done) begin
`ifdef ADC_SCAN_AVG_EN
          if (rep_last)      state_d = ST_STORE;
          else if (stop_eff) state_d = ST_IDLE;
          else               state_d = ST_ACCUM;
`else
          state_d = ST_STORE;
`endif
        end
      end
      ST_STORE: begin
        if (stop_eff) begin
          state_d = ST_IDLE;
        end else if (w_last) begin
          eos = 1'b1;
        end else begin
          w_adv   = 1'b1;
          state_d = ST_SCAN;
        end
      end
`ifdef ADC_SCAN_AVG_EN
      ST_ACCUM: begin
        if (stop_eff) begin
          state_d = ST_IDLE;
        end else begin
          state_d  = ST_ISSUE;
          to_issue = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (eos) begin
      if (cont_q && !stop_eff) begin
        w_load  = 1'b1;
        state_d = ST_SCAN;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // FSM state, scan flags and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      first_q     <= 1'b0;
      cont_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      overrun_q   <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_done_q <= eos;
      if (w_load) begin
        first_q <= 1'b1;
        cont_q  <= mode_cont;
      end else if (state_q == ST_ISSUE) begin
        first_q <= 1'b0;
      end
      if (state_d == ST_IDLE)                stop_pend_q <= 1'b0;
      else if (stop)                         stop_pend_q <= 1'b1;
      if (accept)                            overrun_q   <= 1'b0;
      else if (conv_done && state_q != ST_WAIT) overrun_q <= 1'b1;
    end
  end

  // Choose the settle delay as each conversion is about to be issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_dly_q <= '0;
    end else if (to_issue) begin
      conv_dly_q <= first_q ? first_dly : DLY_W'(INTER_DLY);
    end
  end

`ifdef ADC_SCAN_AVG_EN
  // Accumulate repeated conversions of one channel; abort or completion clears the sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      rep_q <= '0;
    end else if (state_d == ST_IDLE || (state_q == ST_WAIT && state_d == ST_STORE)) begin
      acc_q <= '0;
      rep_q <= '0;
    end else if (state_q == ST_WAIT && conv_done) begin
      acc_q <= acc_sum;
      rep_q <= rep_q + AVG_LOG2'(1);
    end
  end
`endif

  // Capture the finished sample and raise the write strobe for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (state_q == ST_WAIT && state_d == ST_STORE) begin
        out_valid_q <= 1'b1;
`ifdef ADC_SCAN_AVG_EN
        out_data_q  <= {w_chan, acc_sum[AVG_LOG2 +: DATA_W]};
`else
        out_data_q  <= {w_chan, conv_data};
`endif
      end
    end
  end

  assign conv_req  = (state_q == ST_ISSUE) && !stop_eff;
  assign conv_chan = w_chan;
  assign conv_dly  = conv_dly_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != ST_IDLE);
  assign scan_done = scan_done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_adc_scan_seq.sv
// Directed self-checking bench for adc_scan_seq with a fixed-latency engine model.
// Latency: engine replies 20 cycles after conv_req; outputs sampled on the falling edge.
// Backpressure: none; every sample strobe is logged.
module tb_adc_scan_seq;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        start     = 1'b0;
  logic        stop      = 1'b0;
  logic        mode_cont = 1'b0;
  logic [10:0] chan_mask = '0;
  logic [15:0] first_dly = '0;
  logic        conv_req;
  logic [3:0]  conv_chan;
  logic [15:0] conv_dly;
  logic        conv_done = 1'b0;
  logic [11:0] conv_data = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        busy;
  logic        scan_done;
  logic        overrun;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_valid  = 0;
  int n_done   = 0;
  int n_req    = 0;
  int n_busy   = 0;
  int done_cyc = 0;
  int spur_cnt = 0;
  int eng_lat  = 20;
  logic [15:0] samp_q[$];
  logic [15:0] dly_q[$];
  logic [3:0]  chan_q[$];
  int          req_cyc_q[$];

  adc_scan_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .mode_cont (mode_cont),
    .chan_mask (chan_mask),
    .first_dly (first_dly),
    .conv_req  (conv_req),
    .conv_chan (conv_chan),
    .conv_dly  (conv_dly),
    .conv_done (conv_done),
    .conv_data (conv_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .scan_done (scan_done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log DUT activity on the falling edge
  always @(negedge clk) begin
    if (out_valid) begin
      samp_q.push_back(out_data);
      n_valid++;
    end
    if (scan_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (conv_req) begin
      n_req++;
      dly_q.push_back(conv_dly);
      chan_q.push_back(conv_chan);
      req_cyc_q.push_back(cyc);
    end
    if (busy) n_busy++;
  end

  // Engine model: fixed reply latency, plus on-demand spurious conv_done
  initial begin : engine
    int spur_seen;
`ifdef ADC_SCAN_AVG_EN
    int n_resp;
    n_resp = 0;
`else
    int ch;
`endif
    spur_seen = 0;
    forever begin
      @(negedge clk);
      if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        conv_data = 12'hABC;
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
      end else if (conv_req && rst_n) begin
`ifndef ADC_SCAN_AVG_EN
        ch = int'(conv_chan);
`endif
        repeat (eng_lat) @(negedge clk);
`ifdef ADC_SCAN_AVG_EN
        conv_data = 12'(100 + n_resp);
        n_resp++;
`else
        conv_data = 12'(ch * 100 + 7);
`endif
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic pulse_start(input logic [10:0] m, input logic cont, input logic [15:0] fd,
                             output int c0);
    @(posedge clk);
    #1;
    chan_mask = m;
    mode_cont = cont;
    first_dly = fd;
    start     = 1'b1;
    c0        = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int max_cyc, input string tag);
    int i = 0;
    while (n_done == base && i < max_cyc) begin
      @(posedge clk);
      i++;
    end
    #1;
    check(tag, 32'(n_done > base), 1);
  endtask

  task automatic wait_req(input int target, input int max_cyc, input string tag);
    int i = 0;
    while (n_req < target && i < max_cyc) begin
      @(posedge clk);
      i++;
    end
    #1;
    check(tag, 32'(n_req >= target), 1);
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int i = 0;
    while (busy && i < max_cyc) begin
      @(posedge clk);
      i++;
    end
    #1;
    check(tag, 32'(!busy), 1);
  endtask

  function automatic logic [31:0] samp(input int ch, input int res);
    return 32'(ch * 4096 + res);
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c0, b_v, b_d, b_r, b_b;
    int exp_ch[4];
    int exp_dly[4];

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",      busy,      0);
    check("rst_conv_req",  conv_req,  0);
    check("rst_out_valid", out_valid, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_overrun",   overrun,   0);
    check("rst_out_data",  out_data,  0);
    check("rst_conv_chan", conv_chan, 0);
    check("rst_conv_dly",  conv_dly,  0);
    rst_n = 1'b1;

`ifndef ADC_SCAN_AVG_EN
    // Single scan over channels 0, 2, 10
    b_v = n_valid; b_d = n_done; b_r = n_req;
    pulse_start(11'h405, 1'b0, 16'd100, c0);
    wait_done(b_d, 400, "t1_done_timeout");
    repeat (3) @(posedge clk);
    #1;
    check("t1_n_req",   n_req - b_r,   3);
    check("t1_n_valid", n_valid - b_v, 3);
    check("t1_n_done",  n_done - b_d,  1);
    check("t1_busy",    busy,          0);
    check("t1_overrun", overrun,       0);
    if (req_cyc_q.size() > b_r) check("t1_start_to_req", req_cyc_q[b_r] - c0, 2);
    exp_ch  = '{0, 2, 10, 0};
    exp_dly = '{100, 10, 10, 0};
    for (int i = 0; i < 3; i++) begin
      if (samp_q.size() > b_v + i)
        check($sformatf("t1_sample%0d", i), samp_q[b_v + i], samp(exp_ch[i], exp_ch[i] * 100 + 7));
      if (dly_q.size() > b_r + i)
        check($sformatf("t1_dly%0d", i), dly_q[b_r + i], exp_dly[i]);
      if (chan_q.size() > b_r + i)
        check($sformatf("t1_chan%0d", i), chan_q[b_r + i], exp_ch[i]);
    end

    // Continuous scan of channels 0,1; stop while channel 1 of scan 2 converts
    b_v = n_valid; b_d = n_done; b_r = n_req;
    pulse_start(11'h003, 1'b1, 16'd50, c0);
    wait_req(b_r + 4, 600, "t2_req_timeout");
    repeat (5) @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    wait_idle(100, "t2_idle_timeout");
    repeat (30) @(posedge clk);
    #1;
    check("t2_n_valid", n_valid - b_v, 4);
    check("t2_n_done",  n_done - b_d,  1);
    check("t2_n_req",   n_req - b_r,   4);
    exp_ch  = '{0, 1, 0, 1};
    exp_dly = '{50, 10, 50, 10};
    for (int i = 0; i < 4; i++) begin
      if (samp_q.size() > b_v + i)
        check($sformatf("t2_sample%0d", i), samp_q[b_v + i], samp(exp_ch[i], exp_ch[i] * 100 + 7));
      if (dly_q.size() > b_r + i)
        check($sformatf("t2_dly%0d", i), dly_q[b_r + i], exp_dly[i]);
    end

    // Empty mask, single scan: walks all 11 channels then reports done
    b_v = n_valid; b_d = n_done; b_r = n_req;
    pulse_start(11'h000, 1'b0, 16'd5, c0);
    wait_done(b_d, 100, "t3_done_timeout");
    check("t3_start_to_done", done_cyc - c0,  12);
    check("t3_n_valid",       n_valid - b_v,  0);
    check("t3_n_req",         n_req - b_r,    0);
    check("t3_busy",          busy,           0);

    // Spurious conv_done while idle sets overrun; the next start clears it
    b_v = n_valid; b_d = n_done;
    @(posedge clk);
    #1;
    spur_cnt++;
    repeat (3) @(posedge clk);
    #1;
    check("t4_overrun_set", overrun,       1);
    check("t4_n_valid",     n_valid - b_v, 0);
    pulse_start(11'h000, 1'b0, 16'd5, c0);
    check("t4_overrun_clr", overrun, 0);
    wait_done(b_d, 100, "t4_done_timeout");

    // start and stop together: the block must stay idle
    b_b = n_busy; b_r = n_req;
    @(posedge clk);
    #1;
    chan_mask = 11'h001;
    mode_cont = 1'b0;
    start     = 1'b1;
    stop      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t5_busy_cycles", n_busy - b_b, 0);
    check("t5_n_req",       n_req - b_r,  0);

    // Reset while waiting for a conversion clears every output
    b_r = n_req;
    pulse_start(11'h001, 1'b0, 16'd77, c0);
    wait_req(b_r + 1, 50, "t6_req_timeout");
    repeat (3) @(posedge clk);
    #1;
    check("t6_busy_pre", busy,     1);
    check("t6_dly_pre",  conv_dly, 77);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_busy",      busy,      0);
    check("t6_conv_req",  conv_req,  0);
    check("t6_conv_dly",  conv_dly,  0);
    check("t6_conv_chan", conv_chan, 0);
    check("t6_out_data",  out_data,  0);
    check("t6_out_valid", out_valid, 0);
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
`else
    // Averaging: four conversions of channel 0 (100..103) give one sample of 101
    b_v = n_valid; b_d = n_done; b_r = n_req;
    pulse_start(11'h001, 1'b0, 16'd100, c0);
    wait_done(b_d, 600, "avg_done_timeout");
    repeat (3) @(posedge clk);
    #1;
    check("avg_n_req",   n_req - b_r,   4);
    check("avg_n_valid", n_valid - b_v, 1);
    if (samp_q.size() > b_v) check("avg_sample", samp_q[b_v], samp(0, 101));
    exp_dly = '{100, 10, 10, 10};
    for (int i = 0; i < 4; i++) begin
      if (dly_q.size() > b_r + i)
        check($sformatf("avg_dly%0d", i), dly_q[b_r + i], exp_dly[i]);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc_scan_seq.md
Name: adc_scan_seq

Overview:
- Parametrised multi-channel ADC scan sequencer. Walks a latched channel mask, issues one conversion per enabled channel to the serial ADC conversion engine, and emits channel-tagged samples for the sample buffer write port.
- Adds over the previous fixed 11-channel loop:
  - generic channel count and widths
  - single or continuous scan mode
  - graceful stop
  - scan-complete and overrun status
- Sits between the host-command register block and the ADC engine / sample FIFO.

Parameters:
N_CHAN, 11, number of ADC input channels (2..16)
CHAN_W, 4, channel index width, must satisfy 2^CHAN_W >= N_CHAN
DATA_W, 12, conversion result width
DLY_W, 16, engine settle/acquisition delay width
INTER_DLY, 10, delay applied to every conversion after the first of a scan

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin scanning (ignored while busy)
stop  in  1  one-cycle pulse; finish in-flight conversion, then go idle
mode_cont  in  1  0 = single scan, 1 = repeat scans until stop
chan_mask  in  N_CHAN  channel enable mask, bit i = channel i
first_dly  in  DLY_W  delay for the first conversion of each scan
conv_req  out  1  one-cycle pulse to engine: start a conversion
conv_chan  out  CHAN_W  channel for the current conversion, stable while conv_busy
conv_dly  out  DLY_W  delay for the current conversion, stable while conv_busy
conv_done  in  1  one-cycle pulse from engine: result valid
conv_data  in  DATA_W  engine result, valid with conv_done
out_valid  out  1  one-cycle sample strobe (write enable)
out_data  out  CHAN_W+DATA_W  {channel, result}
busy  out  1  high from the cycle after start until return to IDLE
scan_done  out  1  one-cycle pulse when a complete scan finishes
overrun  out  1  sticky; set when conv_done arrives while not in WAIT; cleared by start

Behaviour:
- Reset: all outputs 0; state IDLE; channel counter 0; latched mask 0.
- States: IDLE, SCAN, ISSUE, WAIT, STORE.
- IDLE:
  - On start: latch chan_mask into mask_q, latch mode_cont, set busy, counter = 0, first flag = 1, clear overrun.
  - Next state SCAN.
- SCAN: one channel examined per cycle.
  - mask_q[counter] = 1 -> ISSUE.
  - Else: if counter == N_CHAN-1 -> end-of-scan; otherwise counter++.
- ISSUE:
  - Drive conv_req = 1 for exactly one cycle.
  - conv_chan = counter.
  - conv_dly = first_dly if first flag, else INTER_DLY.
  - Clear first flag. Next state WAIT.
- WAIT: on conv_done, register {counter, conv_data} into out_data and enter STORE.
- STORE:
  - out_valid = 1 for exactly one cycle; out_data holds until the next sample.
  - If counter == N_CHAN-1 -> end-of-scan; otherwise counter++ and go to SCAN.
- End-of-scan:
  - scan_done pulses for one cycle.
  - If mode_cont and no stop is pending: relatch chan_mask, counter = 0, first flag = 1, go to SCAN.
  - Otherwise go to IDLE; busy drops the same cycle the state reaches IDLE.
- Latency:
  - Register start -> conv_req: 2 cycles when channel 0 is enabled.
  - conv_done -> out_valid: 1 cycle.
  - Disabled channels cost 1 cycle each.
- Stop:
  - stop sets a sticky stop_pend flag.
  - In SCAN or ISSUE-pending: go IDLE next cycle without issuing.
  - In WAIT: complete the conversion, emit out_valid, then go IDLE.
  - An aborted scan does not pulse scan_done. stop in IDLE is ignored.
- All-zero mask: scan walks N_CHAN cycles, pulses scan_done, emits no sample. In continuous mode it keeps polling, relatching the mask every scan.
- Simultaneous start and stop in IDLE: stop wins; the block stays idle.
- Overrun: a spurious conv_done outside WAIT is discarded and sets overrun.
- Mask and mode changes mid-scan have no effect until the next scan boundary.
- Reset mid-conversion: the block returns to IDLE immediately. The engine is expected to share rst_n.

Optional Feature:
- Macro ADC_SCAN_AVG_EN adds parameter AVG_LOG2 (default 2) and sub-state ACCUM.
- With the macro:
  - Each enabled channel is converted 2^AVG_LOG2 times back-to-back.
  - The first conversion of the channel uses the scan's delay rule; the repeats use INTER_DLY.
  - Results are summed in a DATA_W+AVG_LOG2 accumulator.
  - out_data carries the sum >> AVG_LOG2 (truncating); one out_valid per channel.
  - Stop during averaging discards the partial sum and emits nothing.
- Without the macro: one conversion per channel, and no accumulator logic is present.

Decomposition:
- Shared package adc_pkg holds:
  - state encoding localparams
  - default widths DATA_W, CHAN_W, DLY_W
  - the out_data field offsets, also used by the sample FIFO and host readout
- Sub-module adc_chan_walker: mask register, channel counter, terminal-count and enabled-bit outputs.
- The FSM, delay mux and output register stay in adc_scan_seq.

Test Plan:
- Single scan, mask 0x405, first_dly 100, engine model replies 20 cycles after conv_req -> 3 out_valid:
  - out_data = {0,r0}, {2,r2}, {10,r10}
  - conv_dly = 100, 10, 10
  - then one scan_done, busy low.
- Continuous, mask 0x003, stop pulsed during WAIT of 2nd scan, channel 1 -> channel-1 sample emitted, then IDLE; exactly one scan_done, 4 out_valid.
- Mask 0 in single mode -> scan_done 12 cycles after start (N_CHAN=11), zero out_valid.
- Spurious conv_done in IDLE -> overrun = 1, no out_valid; next start clears overrun.
- start and stop in the same cycle -> busy stays 0 and conv_req never pulses; reset asserted in WAIT -> all outputs 0 next edge.
- ADC_SCAN_AVG_EN with AVG_LOG2=2, mask 0x001, results 100, 101, 102, 103 -> 4 conv_req, single out_valid with out_data = {0,101}.
